// File: rtl/fir_mac_scheduler.sv
// Round-robin owner selection and tap sequencing for one MAC shared by several FIR channels.
// Each grant runs a full TAPS-cycle evaluation, then pulses done back to the owner.
module fir_mac_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int TAPS      = 20,
  parameter int IDX_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 hold,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_WIDTH-1:0] tap_idx,
  output logic                 mac_valid,
  output logic                 mac_first,
  output logic                 mac_last,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_TAP = IDX_WIDTH'(TAPS - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
  localparam logic [PTR_W-1:0]     LAST_CH  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] owner_idx;

  // Scanning offsets from farthest to nearest lets the nearest requester at or
  // after rr_ptr win, which is the round-robin order.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(rr_ptr) + off) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner_idx = PTR_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      tap_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt     <= ONE_HOT0 << pick_idx;
            tap_idx <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (tap_idx == LAST_TAP) begin
              tap_idx <= '0;
              state   <= S_DONE;
            end else begin
              tap_idx <= tap_idx + IDX_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          rr_ptr <= (owner_idx == LAST_CH) ? '0 : owner_idx + PTR_W'(1);
          gnt    <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from registered state and hold only; req never reaches an output.
  assign mac_valid = (state == S_RUN) && !hold;
  assign mac_first = mac_valid && (tap_idx == '0);
  assign mac_last  = mac_valid && (tap_idx == LAST_TAP);
  assign done      = (state == S_DONE) ? gnt : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: a per-cycle vector table for a single job,
// then hand-written sequences for arbitration order, hold, dropped req and mid-job reset.
module tb_fir_mac_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int TAPS      = 20;
  localparam int IDX_WIDTH = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic                 hold;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_WIDTH-1:0] tap_idx;
  logic                 mac_valid;
  logic                 mac_first;
  logic                 mac_last;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;

  fir_mac_scheduler #(.NUM_REQ(NUM_REQ), .TAPS(TAPS), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clock(clock), .reset(reset), .req(req), .hold(hold),
    .gnt(gnt), .tap_idx(tap_idx), .mac_valid(mac_valid), .mac_first(mac_first),
    .mac_last(mac_last), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] gnt;
    logic [4:0] tap;
    logic       valid;
    logic       first;
    logic       last;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic h, input logic [3:0] g,
                              input int t, input logic v, input logic f, input logic l,
                              input logic [3:0] d, input logic b);
    vec_t x;
    x.req = r; x.hold = h; x.gnt = g; x.tap = 5'(t); x.valid = v;
    x.first = f; x.last = l; x.done = d; x.busy = b;
    return x;
  endfunction

  // Runs one job from its mac_first cycle up to and including its done cycle.
  // Optionally holds for hold_n cycles at tap hold_tap, or drops req drop_after cycles in.
  task automatic job(input logic [3:0] exp_gnt, input int hold_tap, input int hold_n,
                     input int drop_after);
    int guard;
    int vcount;
    int t0;
    bit gnt_ok;
    bit held;
    guard = 0;
    while (!mac_first && guard < 40) begin
      tick();
      guard++;
    end
    check("job_start", 32'(mac_first), 32'd1);
    check("job_gnt", 32'(gnt), 32'(exp_gnt));
    t0 = cyc;
    first_cyc = t0;
    vcount = 0;
    gnt_ok = 1'b1;
    held = 1'b0;
    guard = 0;
    while (done == '0 && guard < 100) begin
      if (hold_n > 0 && !held && mac_valid && int'(tap_idx) == hold_tap) begin
        for (int h = 0; h < hold_n; h++) begin
          hold = 1'b1;
          #1;
          check("hold_tap", 32'(tap_idx), 32'(hold_tap));
          check("hold_valid", 32'(mac_valid), 32'd0);
          tick();
        end
        hold = 1'b0;
        held = 1'b1;
        #1;
      end
      if (drop_after >= 0 && cyc - t0 == drop_after) begin
        req = '0;
        #1;
      end
      if (mac_valid) vcount++;
      if (gnt !== exp_gnt) gnt_ok = 1'b0;
      tick();
      guard++;
    end
    check("job_done", 32'(done), 32'(exp_gnt));
    check("job_done_gnt", 32'(gnt), 32'(exp_gnt));
    check("job_len", 32'(cyc - t0), 32'(TAPS + hold_n));
    check("job_valid_count", 32'(vcount), 32'(TAPS));
    check("job_gnt_stable", 32'(gnt_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[23];
    logic [3:0] order_all[5];
    logic [3:0] order_02[4];
    int prev_first;
    int guard;
    bit saw_done;

    // Single job on channel 1; hold is high in IDLE and DONE where it must be ignored.
    vecs[0] = mk(4'b0010, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int t = 1; t <= TAPS; t++)
      vecs[t] = mk(4'b0010, 1'b0, 4'b0010, t - 1, 1'b1, t == 1, t == TAPS, 4'b0000, 1'b1);
    vecs[21] = mk(4'b0010, 1'b1, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1);
    vecs[22] = mk(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    order_all = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    order_02  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tap", 32'(tap_idx), 32'd0);
    check("rst_valid", 32'(mac_valid), 32'd0);
    check("rst_first", 32'(mac_first), 32'd0);
    check("rst_last", 32'(mac_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      req  = vecs[i].req;
      hold = vecs[i].hold;
      #1;
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_tap", i), 32'(tap_idx), 32'(vecs[i].tap));
      check($sformatf("v%0d_valid", i), 32'(mac_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_first", i), 32'(mac_first), 32'(vecs[i].first));
      check($sformatf("v%0d_last", i), 32'(mac_last), 32'(vecs[i].last));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      tick();
    end
    check("rr_ptr_after_ch1", 32'(dut.rr_ptr), 32'd2);

    // All four requesting: order continues from rr_ptr=2, one start every TAPS+2 cycles.
    hold = 1'b0;
    req  = 4'b1111;
    prev_first = 0;
    for (int j = 0; j < 5; j++) begin
      job(order_all[j], -1, 0, -1);
      if (j > 0) check("first_gap", 32'(first_cyc - prev_first), 32'(TAPS + 2));
      prev_first = first_cyc;
      if (j == 4) req = '0;
      tick();
    end

    // Channels 0 and 2 only, rr_ptr=3: alternate 0,2,0,2.
    req = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      job(order_02[j], -1, 0, -1);
      if (j == 3) req = '0;
      tick();
    end

    // Five hold cycles at tap 7 stretch the job by five cycles.
    req = 4'b0001;
    job(4'b0001, 7, 5, -1);
    req = '0;
    tick();

    // Channel 3 drops req two cycles into its job; the job still completes.
    req = 4'b1000;
    job(4'b1000, -1, 0, 2);
    req = 4'b1111;
    tick();
    check("rr_ptr_after_ch3", 32'(dut.rr_ptr), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    job(4'b0001, -1, 0, -1);
    req = 4'b0010;
    tick();

    // Reset at tap 10 drops the job; held req1 is re-granted from rr_ptr=0.
    guard = 0;
    saw_done = 1'b0;
    while (!(busy && tap_idx == 5'd10) && guard < 60) begin
      if (done != '0) saw_done = 1'b1;
      tick();
      guard++;
    end
    check("reached_tap10", 32'(tap_idx), 32'd10);
    check("reached_tap10_gnt", 32'(gnt), 32'b0010);
    reset = 1'b1;
    #1;
    if (done != '0) saw_done = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    check("no_done_before_rst", 32'(saw_done), 32'd0);
    tick();
    check("regrant_gnt", 32'(gnt), 32'b0010);
    check("regrant_tap", 32'(tap_idx), 32'd0);
    check("regrant_first", 32'(mac_first), 32'd1);
    job(4'b0010, -1, 0, -1);
    req = '0;
    tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
